// File: rtl/fetch_queue.sv
// Instruction prefetch queue: a single-outstanding fetch FSM feeding a DEPTH-entry FIFO
// of {pc, ir} pairs. A redirect flushes the queue and drops any in-flight result.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t         state, state_nxt;
    logic [31:0]    fpc;
    logic [CW-1:0]  count, count_pop, count_nxt;
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [31:0]    pc_mem [DEPTH];
    logic [31:0]    ir_mem [DEPTH];
    logic           hs, push, pop;

    assign imem_req  = (state != IDLE);
    assign imem_addr = fpc;
    assign hs        = imem_req & imem_ack;
    assign out_valid = (count != '0);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_ir    = ir_mem[rd_ptr];

    // redirect overrides both ends of the queue in the same cycle
    assign pop       = out_valid & ~stall & ~redirect;
    assign push      = (state == REQ) & hs & ~redirect;
    assign count_pop = count - CW'(pop);
    assign count_nxt = count_pop + CW'(push);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect || count_pop < CW'(DEPTH))
                    state_nxt = REQ;
            end
            REQ: begin
                if (redirect)
                    state_nxt = hs ? REQ : DISCARD;
                else if (hs)
                    state_nxt = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
            end
            DISCARD: begin
                if (hs)
                    state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= REQ;
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                // masking keeps every redirect_pc bit in use while forcing word alignment
                fpc    <= redirect_pc & 32'hFFFF_FFFC;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (push) begin
                    fpc    <= fpc + 32'd4;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr] <= fpc;
            ir_mem[wr_ptr] <= imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-configurable memory returning the request address as
// data, with a scoreboard of expected {pc == ir} values checked on every pop.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_ir;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    // memory model: ack after lat cycles of req, data = address latched at request start
    int          lat = 1;
    int          wcnt = 0;
    logic [31:0] lat_addr = '0;
    logic        force_ack = 1'b0;

    assign imem_ack  = force_ack | (imem_req & (wcnt == lat - 1));
    assign imem_data = (wcnt == 0) ? imem_addr : lat_addr;

    always @(posedge clk) begin
        if (reset)
            wcnt <= 0;
        else if (imem_req) begin
            if (wcnt == lat - 1)
                wcnt <= 0;
            else begin
                if (wcnt == 0) lat_addr <= imem_addr;
                wcnt <= wcnt + 1;
            end
        end
    end

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic sb_fill(input logic [31:0] start, input int n);
        logic [31:0] a;
        sb.delete();
        a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic test_reset();
        lat = 1;
        redirect = 1'b1; redirect_pc = 32'h0000_7000;
        stall = 1'b1; force_ack = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; redirect = 1'b0; force_ack = 1'b0; stall = 1'b0;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            bad++;
            $display("FAIL reset_state: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00003000",
                     out_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        lat = 1;
        apply_reset();
        sb_fill(32'h0000_3000, 16);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 + 32'(4 * i)) begin
                    bad++;
                    $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h",
                             i, imem_req, imem_addr, 32'h0000_3000 + 32'(4 * i));
                end
            end
            if (i < 2) begin
                total++;
                if (out_valid !== (i == 1)) begin
                    bad++;
                    $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, (i == 1));
                end
            end
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL stream_pop: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL stream_pop: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        int pops = 0;
        lat = 1;
        apply_reset();
        stall = 1'b1;
        sb_fill(32'h0000_3000, 16);
        for (int i = 0; i < 6; i++) begin
            if (i >= 1) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0000_3000) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got valid=%b pc=%h want valid=1 pc=00003000",
                             i, out_valid, out_pc);
                end
            end
            if (i >= 3) begin
                total++;
                if (imem_req !== (i == 3)) begin
                    bad++;
                    $display("FAIL stall_req[%0d]: got %b want %b", i, imem_req, (i == 3));
                end
            end
            step();
        end
        stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3010) begin
                    bad++;
                    $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00003010",
                             imem_req, imem_addr);
                end
            end
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL stall_drain: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL stall_drain: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
        total++;
        if (pops < 6) begin
            bad++;
            $display("FAIL stall_drain_count: got %0d pops want >=6", pops);
        end
    endtask

    task automatic test_redirect_latency();
        logic [31:0] e;
        int pops = 0;
        int guard = 0;
        lat = 3;
        apply_reset();
        while (!(imem_req && imem_addr == 32'h0000_3008) && guard < 40) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++;
            $display("FAIL redir_lat_wait: got addr=%h want 00003008", imem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_3402;
        step();
        redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL redir_lat_flush: got valid=%b req=%b want valid=0 req=1", out_valid, imem_req);
        end
        sb_fill(32'h0000_3400, 8);
        for (int i = 0; i < 16; i++) begin
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL redir_lat_pop: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL redir_lat_pop: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
        total++;
        if (pops < 2) begin
            bad++;
            $display("FAIL redir_lat_count: got %0d pops want >=2", pops);
        end
    endtask

    task automatic test_redirect_ack();
        logic [31:0] e;
        int pops = 0;
        lat = 1;
        apply_reset();
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_5003;
        step();
        redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_5000) begin
            bad++;
            $display("FAIL redir_ack: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00005000",
                     out_valid, imem_req, imem_addr);
        end
        sb_fill(32'h0000_5000, 8);
        for (int i = 0; i < 6; i++) begin
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL redir_ack_pop: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL redir_ack_pop: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
        total++;
        if (pops < 4) begin
            bad++;
            $display("FAIL redir_ack_count: got %0d pops want >=4", pops);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        sb_fill(32'hFFFF_FFFC, 8);
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                total++;
                if (imem_addr !== (i == 0 ? 32'hFFFF_FFFC : 32'h0000_0000)) begin
                    bad++;
                    $display("FAIL wrap_addr[%0d]: got %h want %h", i, imem_addr,
                             (i == 0 ? 32'hFFFF_FFFC : 32'h0000_0000));
                end
            end
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wrap_pop: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL wrap_pop: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e;
        int guard = 0;
        lat = 3;
        apply_reset();
        stall = 1'b1;
        while (imem_req && guard < 40) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 40 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_fill: got req=%b valid=%b want req=0 valid=1", imem_req, out_valid);
        end
        stall = 1'b0;
        step();
        stall = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pending: got req=%b valid=%b want req=1 valid=1", imem_req, out_valid);
        end
        reset = 1'b1; force_ack = 1'b1;
        step();
        reset = 1'b0; force_ack = 1'b0; stall = 1'b0; lat = 1;
        total++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            bad++;
            $display("FAIL midrst_state: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00003000",
                     out_valid, imem_req, imem_addr);
        end
        sb_fill(32'h0000_3000, 8);
        for (int i = 0; i < 5; i++) begin
            if (out_valid && !stall && !redirect) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL midrst_pop: got pc=%h want no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e || out_ir !== e) begin
                        bad++;
                        $display("FAIL midrst_pop: got pc=%h ir=%h want %h", out_pc, out_ir, e);
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_ack();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
